// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, ALU
// operation codes, datapath mux selects and the state encoding.
package multi_cycle_ctrl_pkg;

  // Opcodes, taken from IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLTI  = 3'b100;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11
  } state_t;

  // State following DECODE; unsupported opcodes fall back to FETCH.
  function automatic state_t decodeNext(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:       nxt = ST_R_EXEC;
      OP_LW, OP_SW:   nxt = ST_MEM_ADDR;
      OP_ADDI,
      OP_SLTI:        nxt = ST_I_EXEC;
      OP_BEQ:         nxt = ST_BRANCH;
      OP_J:           nxt = ST_JUMP;
      default:        nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_wait.sv
// mem_wait_timer: counts consecutive memory stall cycles and raises a sticky
// timeout once a single access has stalled WAIT_MAX cycles.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic waitCycle,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] cntNext;

  // Next count: any non-stall cycle (which includes every state change) clears, stalls saturate
  always_comb begin
    cntNext = waitCnt;
    if (!waitCycle) begin
      cntNext = '0;
    end else if (waitCnt != CNT_MAX) begin
      cntNext = waitCnt + 1'b1;
    end
  end

  // Counter register and sticky timeout, only reset clears the flag
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      waitCnt <= '0;
      timeout <= 1'b0;
    end else begin
      waitCnt <= cntNext;
      if (waitCycle && (cntNext >= WAIT_LIMIT)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback on a shared ALU and unified memory.
//
// Memory handshake: while the FSM presents MemRead_o or MemWrite_o, the access
// completes in the cycle mem_ready_i is high; with mem_ready_i low the request
// and every other control stay unchanged into the next cycle.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALU_op_o,
  output logic [1:0] PCSource_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       timeout_o,
  output logic [3:0] state_o
);

  state_t     state;
  logic [5:0] opReg;
  logic       waitCycle;
  logic       timeoutRaw;

  // A stall cycle is a memory-requesting state without ready
  assign waitCycle = ((state == ST_FETCH) || (state == ST_MEM_RD) ||
                      (state == ST_MEM_WR)) && !mem_ready_i;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) uWaitTimer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .waitCycle (waitCycle),
    .timeout   (timeoutRaw)
  );

  assign timeout_o = rst_i & timeoutRaw;
  assign state_o   = state;

  // State register; opcode is captured in DECODE (IR is stable afterwards)
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_FETCH;
      opReg <= '0;
    end else begin
      case (state)
        ST_FETCH:    if (mem_ready_i) state <= ST_DECODE;
        ST_DECODE: begin
          opReg <= instr_op_i;
          state <= decodeNext(instr_op_i);
        end
        ST_MEM_ADDR: state <= (opReg == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   if (mem_ready_i) state <= ST_MEM_WB;
        ST_MEM_WR:   if (mem_ready_i) state <= ST_FETCH;
        ST_R_EXEC:   state <= ST_R_WB;
        ST_I_EXEC:   state <= ST_I_WB;
        default:     state <= ST_FETCH;
      endcase
    end
  end

  // Control outputs from state and mem_ready_i; everything is 0 in reset
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_RT;
    ALU_op_o      = ALU_ADD;
    PCSource_o    = PCSRC_ALU;
    instr_done_o  = 1'b0;
    illegal_o     = 1'b0;
    if (rst_i) begin
      case (state)
        ST_FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = SRCB_FOUR;
          if (mem_ready_i) begin
            IRWrite_o = 1'b1;
            PCWrite_o = 1'b1;
          end
        end
        ST_DECODE: begin
          ALUSrcB_o = SRCB_IMM_SH;
          if (decodeNext(instr_op_i) == ST_FETCH) begin
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
          end
        end
        ST_MEM_ADDR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = SRCB_IMM;
        end
        ST_MEM_RD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
        end
        ST_MEM_WB: begin
          RegWrite_o   = 1'b1;
          MemtoReg_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        ST_MEM_WR: begin
          MemWrite_o   = 1'b1;
          IorD_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        ST_R_EXEC: begin
          ALUSrcA_o = 1'b1;
          ALU_op_o  = ALU_FUNCT;
        end
        ST_R_WB: begin
          RegWrite_o   = 1'b1;
          RegDst_o     = 1'b1;
          instr_done_o = 1'b1;
        end
        ST_I_EXEC: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = SRCB_IMM;
          ALU_op_o  = (opReg == OP_SLTI) ? ALU_SLTI : ALU_ADD;
        end
        ST_I_WB: begin
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA_o     = 1'b1;
          ALU_op_o      = ALU_SUB;
          PCWriteCond_o = 1'b1;
          PCSource_o    = PCSRC_ALUOUT;
          instr_done_o  = 1'b1;
        end
        ST_JUMP: begin
          PCWrite_o    = 1'b1;
          PCSource_o   = PCSRC_JUMP;
          instr_done_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: a driver issues whole instructions with chosen
// memory wait counts and pushes a per-instruction signature (latency, number
// of cycles each control was active, final state, timeout) built from the
// instruction's phases; a monitor accumulates the same signature from the DUT
// and compares it whenever instr_done_o pulses.
module tb_multi_cycle_ctrl;

  localparam int WAIT_MAX = 15;
  localparam int NF = 22;
  localparam int W  = NF * 8;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_SLTI  = 6'b001010;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_J     = 6'b000010;

  localparam int F_CYC = 0, F_MEMRD = 1, F_MEMWR = 2, F_IORD = 3, F_REGWR = 4,
                 F_MEMTOREG = 5, F_REGDST = 6, F_PCWR = 7, F_PCCOND = 8,
                 F_IRWR = 9, F_ILLEGAL = 10, F_SRCA = 11, F_SRCB4 = 12,
                 F_SRCBSH = 13, F_SRCBIMM = 14, F_ALUFN = 15, F_ALUSUB = 16,
                 F_ALUSLTI = 17, F_PCSOUT = 18, F_PCSJMP = 19, F_DONEST = 20,
                 F_TO = 21;

  string fieldName [NF] = '{"cycles", "memread_cycles", "memwrite_cycles",
    "iord_cycles", "regwrite_cycles", "memtoreg_cycles", "regdst_cycles",
    "pcwrite_cycles", "pcwritecond_cycles", "irwrite_cycles", "illegal_cycles",
    "alusrca_cycles", "alusrcb_four_cycles", "alusrcb_immsh_cycles",
    "alusrcb_imm_cycles", "aluop_funct_cycles", "aluop_sub_cycles",
    "aluop_slti_cycles", "pcsource_aluout_cycles", "pcsource_jump_cycles",
    "done_state", "timeout_at_done"};

  // ---------------- clock / reset / DUT ----------------
  logic       clk_i;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
  logic       IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALU_op_o;
  logic [1:0] PCSource_o;
  logic       instr_done_o, illegal_o, timeout_o;
  logic [3:0] state_o;
  logic [19:0] allOut;

  assign allOut = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                   IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
                   ALUSrcB_o, ALU_op_o, PCSource_o, instr_done_o, illegal_o,
                   timeout_o};

  multi_cycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_op_i    (instr_op_i),
    .mem_ready_i   (mem_ready_i),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .MemtoReg_o    (MemtoReg_o),
    .RegDst_o      (RegDst_o),
    .RegWrite_o    (RegWrite_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .ALU_op_o      (ALU_op_o),
    .PCSource_o    (PCSource_o),
    .instr_done_o  (instr_done_o),
    .illegal_o     (illegal_o),
    .timeout_o     (timeout_o),
    .state_o       (state_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- scoreboard state ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];
  bit timeoutModel;
  int obs [NF];

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {T_RTYPE, T_ADDI, T_SLTI, T_LW, T_SW, T_BEQ, T_J};
  endfunction

  // Reference signature of one instruction: fw fetch stalls, mw data stalls
  function automatic logic [W-1:0] model(input logic [5:0] op, input int fw,
                                         input int mw, input bit to);
    int f [NF];
    logic [W-1:0] v;
    foreach (f[i]) f[i] = 0;
    // every instruction starts with a fetch and a decode cycle
    f[F_MEMRD]  = fw + 1;
    f[F_SRCB4]  = fw + 1;
    f[F_IRWR]   = 1;
    f[F_PCWR]   = 1;
    f[F_SRCBSH] = 1;
    f[F_TO]     = int'(to);
    case (op)
      T_LW: begin
        f[F_CYC] = 5 + fw + mw;  f[F_MEMRD] += mw + 1;  f[F_IORD] = mw + 1;
        f[F_REGWR] = 1;  f[F_MEMTOREG] = 1;  f[F_SRCA] = 1;  f[F_SRCBIMM] = 1;
        f[F_DONEST] = 4;
      end
      T_SW: begin
        f[F_CYC] = 4 + fw + mw;  f[F_MEMWR] = mw + 1;  f[F_IORD] = mw + 1;
        f[F_SRCA] = 1;  f[F_SRCBIMM] = 1;  f[F_DONEST] = 5;
      end
      T_RTYPE: begin
        f[F_CYC] = 4 + fw;  f[F_SRCA] = 1;  f[F_ALUFN] = 1;
        f[F_REGWR] = 1;  f[F_REGDST] = 1;  f[F_DONEST] = 7;
      end
      T_ADDI, T_SLTI: begin
        f[F_CYC] = 4 + fw;  f[F_SRCA] = 1;  f[F_SRCBIMM] = 1;
        f[F_ALUSLTI] = (op == T_SLTI) ? 1 : 0;
        f[F_REGWR] = 1;  f[F_DONEST] = 11;
      end
      T_BEQ: begin
        f[F_CYC] = 3 + fw;  f[F_SRCA] = 1;  f[F_ALUSUB] = 1;
        f[F_PCCOND] = 1;  f[F_PCSOUT] = 1;  f[F_DONEST] = 8;
      end
      T_J: begin
        f[F_CYC] = 3 + fw;  f[F_PCWR] = 2;  f[F_PCSJMP] = 1;  f[F_DONEST] = 9;
      end
      default: begin
        f[F_CYC] = 2 + fw;  f[F_ILLEGAL] = 1;  f[F_DONEST] = 1;
      end
    endcase
    for (int i = 0; i < NF; i++) v[i*8 +: 8] = 8'(f[i]);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] op, input logic rdy);
    instr_op_i  = op;
    mem_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [5:0] rndOp();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
    bit toBefore;
    bit isMem;
    toBefore = timeoutModel;
    isMem = (op == T_LW) || (op == T_SW);
    if (fw >= WAIT_MAX || (isMem && mw >= WAIT_MAX)) timeoutModel = 1'b1;
    exp_q.push_back(model(op, fw, mw, timeoutModel));
    for (int i = 0; i < fw; i++) begin
      drive(rndOp(), 1'b0);
      if (i + 1 == WAIT_MAX - 1) check("timeout_before_limit", int'(timeout_o), int'(toBefore));
      if (i + 1 == WAIT_MAX)     check("timeout_at_limit", int'(timeout_o), 1);
    end
    drive(rndOp(), 1'b1);          // fetch completes
    drive(op, rndBit());           // decode
    case (op)
      T_LW: begin
        drive(op, rndBit());
        for (int i = 0; i < mw; i++) drive(op, 1'b0);
        drive(op, 1'b1);
        drive(op, rndBit());
      end
      T_SW: begin
        drive(op, rndBit());
        for (int i = 0; i < mw; i++) drive(op, 1'b0);
        drive(op, 1'b1);
      end
      T_RTYPE, T_ADDI, T_SLTI: begin
        drive(op, rndBit());
        drive(op, rndBit());
      end
      T_BEQ, T_J: drive(op, rndBit());
      default: ;
    endcase
  endtask

  task automatic runRandom();
    logic [5:0] op;
    case ($urandom_range(0, 7))
      0: op = T_RTYPE;
      1: op = T_ADDI;
      2: op = T_SLTI;
      3: op = T_LW;
      4: op = T_SW;
      5: op = T_BEQ;
      6: op = T_J;
      default: begin
        op = rndOp();
        while (isLegal(op)) op = rndOp();
      end
    endcase
    runInstr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (!rst_i) begin
      foreach (obs[i]) obs[i] = 0;
    end else begin
      obs[F_CYC]++;
      if (MemRead_o)                obs[F_MEMRD]++;
      if (MemWrite_o)               obs[F_MEMWR]++;
      if (IorD_o)                   obs[F_IORD]++;
      if (RegWrite_o)               obs[F_REGWR]++;
      if (MemtoReg_o)               obs[F_MEMTOREG]++;
      if (RegDst_o)                 obs[F_REGDST]++;
      if (PCWrite_o)                obs[F_PCWR]++;
      if (PCWriteCond_o)            obs[F_PCCOND]++;
      if (IRWrite_o)                obs[F_IRWR]++;
      if (illegal_o)                obs[F_ILLEGAL]++;
      if (ALUSrcA_o)                obs[F_SRCA]++;
      if (ALUSrcB_o == 2'b01)       obs[F_SRCB4]++;
      if (ALUSrcB_o == 2'b11)       obs[F_SRCBSH]++;
      if (ALUSrcB_o == 2'b10)       obs[F_SRCBIMM]++;
      if (ALU_op_o == 3'b010)       obs[F_ALUFN]++;
      if (ALU_op_o == 3'b001)       obs[F_ALUSUB]++;
      if (ALU_op_o == 3'b100)       obs[F_ALUSLTI]++;
      if (PCSource_o == 2'b01)      obs[F_PCSOUT]++;
      if (PCSource_o == 2'b10)      obs[F_PCSJMP]++;
      if (instr_done_o) begin
        obs[F_DONEST] = int'(state_o);
        obs[F_TO]     = int'(timeout_o);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done pulse in state %0d, expected no instruction pending", state_o);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < NF; i++) check(fieldName[i], obs[i], int'(e[i*8 +: 8]));
        end
        foreach (obs[i]) obs[i] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_i        = 1'b0;
    mem_ready_i  = 1'b1;
    instr_op_i   = 6'b0;
    timeoutModel = 1'b0;

    repeat (2) begin
      @(negedge clk_i);
      check("reset_outputs", int'(allOut), 0);
      check("reset_state", int'(state_o), 0);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // directed cases
    runInstr(T_LW, 0, 0);
    runInstr(T_RTYPE, 0, 0);
    runInstr(T_BEQ, 0, 0);
    runInstr(T_SW, 0, 3);
    runInstr(6'b111111, 0, 0);
    runInstr(T_ADDI, 1, 0);
    runInstr(T_SLTI, 0, 0);
    runInstr(T_J, 0, 0);
    runInstr(T_LW, 2, 2);

    repeat (30) runRandom();

    // long fetch stall crosses the timeout limit
    runInstr(T_J, 16, 0);
    repeat (10) runRandom();

    // reset in the middle of a lw (DUT sits in the address cycle)
    drive(rndOp(), 1'b1);
    drive(T_LW, 1'b1);
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    check("reset_cycle_outputs", int'(allOut), 0);
    @(posedge clk_i);
    #1;
    check("reset_abort_state", int'(state_o), 0);
    rst_i = 1'b1;
    timeoutModel = 1'b0;
    #1;
    check("timeout_cleared", int'(timeout_o), 0);

    repeat (5) runRandom();

    @(negedge clk_i);
    check("pending_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
